piso_tx_5: RTL
==============

# piso_tx_5

Parallel-in, serial-out transmitter forming the sending end of the 5-bit shift link whose receiving end is the `dff_5` SIPO chain. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per enable tick. It also drives the shift-enable that the receiving chain uses as its `en`. Bit 0 is sent first, so a receiving chain clocked by `sen` holds the original word on `out[4:0]` after WIDTH ticks.

## Interface
- `WIDTH`, 5, word length in bits; legal range 2..32
- `clk`  in  1  single system clock; all state changes on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `din`  in  WIDTH  parallel word to transmit
- `load_valid`  in  1  `din` is valid this cycle
- `load_ready`  out  1  transmitter can accept `din` this cycle; a transfer occurs when `load_valid` and `load_ready` are both high at a rising edge
- `en`  in  1  shift tick (bit-rate strobe); may be held high continuously
- `sout`  out  1  serial data, registered
- `sen`  out  1  qualified shift enable to the receiver, `en` gated with SHIFT state
- `busy`  out  1  a word is being shifted
- `done`  out  1  one-cycle pulse after the last bit of a word has been shifted

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - `load_ready`=1; `sout`=0; `sen`=0.
  - On accept: `shreg`<=`din`; `sout`<=`din[0]`; `cnt`<=0; go to SHIFT.
  - `en` is ignored in IDLE. The load cycle never shifts.
- SHIFT:
  - `sen` = `en`.
  - On each edge with `en`=1, the receiver captures `sout`; `shreg`<=`shreg>>1`; `sout`<=next bit; `cnt`<=`cnt`+1.
  - Edges with `en`=0 hold all state.
- Last bit: an edge with `en`=1 and `cnt`=WIDTH-1.
  - `done`<=1 for one cycle.
  - If `load_valid`=1 in that cycle, the next word is loaded (back-to-back) and the block stays in SHIFT. Otherwise it goes to IDLE and `sout`<=0.
- `load_ready` = IDLE, or (SHIFT and `en` and `cnt`==WIDTH-1). It is combinational from state and `en`.
- `load_valid` in SHIFT outside the last-bit cycle is not accepted. `din` is not sampled.
- `busy` = SHIFT state, registered.
- Counter width: `$clog2(WIDTH)`. `cnt` wraps only through a reload; it never exceeds WIDTH-1.
- Reset (`rst`=0 at an edge), in any state including mid-word:
  - state=IDLE; `shreg`=0; `cnt`=0; `sout`=0; `busy`=0; `done`=0.
  - The partial word is discarded with no `done` pulse.
  - `load_ready` and `sen` are forced to 0 while `rst`=0.

## Timing
- Load-to-first-bit: `sout` shows `din[0]` in the cycle after the accepting edge. It is captured at the first subsequent edge with `en`=1.
- With `en` tied high: one word per WIDTH cycles, sustained, with no gap when `load_valid` is held. `done` asserts in the cycle after the WIDTH-th `sen` edge.
- `sen` edges per word: exactly WIDTH. No `sen` pulse may occur in IDLE or during reset.
- `sout` changes only on edges where a shift or load occurs. It is stable for the whole cycle in which `sen`=1.
- Simultaneous reset and load: reset wins; nothing is accepted.

## Structure
- Package `piso_pkg`:
  - `state_t` enum {IDLE, SHIFT}.
  - `PISO_WIDTH_DEF`=5.
- Sub-module `piso_bit_cnt`: enabled up-counter with synchronous active-low reset and clear-on-load. Outputs `cnt` and `last` (`cnt`==WIDTH-1).
- The top module holds the FSM, `shreg`, the `sout` register, and the handshake logic.

## Test plan
- Reset, then `din`=5'b10110, one `load_valid` pulse, `en`=1 constant → `sout` over the 5 `sen` cycles = 0,1,1,0,1. A `dff_5` driven by `sen`/`sout` shows `out`=5'b10110. `done` pulses once; `load_ready` returns to 1.
- `en` toggling 1,0,0,1,… during word 5'b00011 → shift only on `en`=1 edges. Exactly 5 `sen` pulses; `sout` holds between them; `done` follows the 5th.
- Back-to-back: `load_valid` held with 5'b11111 then 5'b00000, `en`=1 → 10 consecutive `sen` cycles: five 1s then five 0s. Two `done` pulses 5 cycles apart; `busy` never drops.
- `load_valid` with 5'b01010 asserted at `cnt`=2 of a running word → not accepted; `load_ready`=0. Accepted only in the last-bit cycle.
- Reset asserted at `cnt`=3 → next cycle `sout`=0, `busy`=0, no `done`. A fresh load of 5'b10001 transmits correctly.
- Reset held with `load_valid`=1 and `en`=1 → `load_ready`=0 and `sen`=0 throughout; no state change.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and defaults for the 5-bit PISO transmitter.
// The state encoding is common to the FSM and any observers.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int PISO_WIDTH_DEF = 5;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for the PISO transmitter: counts shift ticks within a word
// and flags the final bit position. Clear has priority over increment.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == LAST_POS);

endmodule

// File: rtl/piso_tx_5.sv
// Parallel-in serial-out transmitter: loads a word over valid/ready and sends it
// LSB first, one bit per qualified enable tick, driving the receiver's shift enable.
module piso_tx_5
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             sout,
    output logic             sen,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic             sout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CW-1:0]    cnt;
    logic             last;
    logic             in_shift;
    logic             accept;
    logic             cnt_clr;
    logic             unused_cnt;

    assign in_shift   = (state_reg == SHIFT);
    assign sen        = rst && in_shift && en;
    assign load_ready = rst && (!in_shift || (en && last));
    assign accept     = load_valid && load_ready;

    // The counter restarts on every load and after the final bit of a word.
    assign cnt_clr    = accept || (sen && last);

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (sen),
        .cnt  (cnt),
        .last (last)
    );

    // Only the last-position flag steers control; the raw count is kept for debug.
    assign unused_cnt = ^cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            sout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shreg_reg <= din;
                        sout_reg  <= din[0];
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        if (last) begin
                            done_reg <= 1'b1;
                            if (load_valid) begin
                                shreg_reg <= din;
                                sout_reg  <= din[0];
                            end else begin
                                shreg_reg <= '0;
                                sout_reg  <= 1'b0;
                                busy_reg  <= 1'b0;
                                state_reg <= IDLE;
                            end
                        end else begin
                            // sout always mirrors shreg[0], so the next bit is shreg[1].
                            shreg_reg <= shreg_reg >> 1;
                            sout_reg  <= shreg_reg[1];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sout = sout_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
